// File: rtl/wide_bus_pkg.sv
// Shared definitions for the wide-bus beat serializer: default bus widths,
// the derived beat geometry and the serializer state encoding.
package wide_bus_pkg;

  localparam int ULTRA_WIDE_W = 1024;
  localparam int LINK_BEAT_W  = 32;
  localparam int NUM_BEATS    = ULTRA_WIDE_W / LINK_BEAT_W;
  localparam int IDX_W        = $clog2(NUM_BEATS);

  typedef enum logic {IDLE, SEND} state_t;

endpackage

// File: rtl/wide_bus_beat_serializer.sv
// Splits one wide word per handshake into NUM_BEATS narrow beats, LSB slice
// first, with zero-bubble back-to-back words and a wrapping frame counter.
module wide_bus_beat_serializer
  import wide_bus_pkg::*;
#(
  parameter int WIDE_W  = ULTRA_WIDE_W,
  parameter int BEAT_W  = LINK_BEAT_W,
  parameter int COUNT_W = 16
) (
  input  logic                                main_clk_100mhz,
  input  logic                                reset,
  input  logic                                wide_valid,
  output logic                                wide_ready,
  input  logic [WIDE_W-1:0]                   wide_data,
  output logic                                beat_valid,
  input  logic                                beat_ready,
  output logic [BEAT_W-1:0]                   beat_data,
  output logic [$clog2(WIDE_W/BEAT_W)-1:0]    beat_idx,
  output logic                                beat_last,
  output logic [COUNT_W-1:0]                  frame_count,
  output logic                                busy
);

  localparam int NB = WIDE_W / BEAT_W;
  localparam int IW = $clog2(NB);
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  if ((WIDE_W % BEAT_W) != 0 || NB < 2) begin : g_bad_geometry
    $error("wide_bus_beat_serializer: WIDE_W must be a multiple of BEAT_W with at least 2 beats");
  end

  state_t              state, state_nxt;
  logic [WIDE_W-1:0]   shadow;
  logic [IW-1:0]       idx;
  logic [COUNT_W-1:0]  fcnt;

  logic beat_fire;
  logic at_last;
  logic accept;

  assign at_last   = (idx == LAST_IDX);
  assign beat_fire = beat_valid && beat_ready;

  // Only combinational input-to-output path: the last beat's handshake frees
  // the shadow register in the same cycle, giving back-to-back words.
  assign wide_ready = !reset && ((state == IDLE) ||
                                 ((state == SEND) && beat_last && beat_ready));
  assign accept     = wide_valid && wide_ready;

  always_ff @(posedge main_clk_100mhz) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (wide_valid) state_nxt = SEND;
      SEND: if (beat_fire && at_last && !wide_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge main_clk_100mhz) begin
    if (reset) begin
      shadow <= '0;
      idx    <= '0;
      fcnt   <= '0;
    end else begin
      if (beat_fire) begin
        if (at_last) begin
          idx  <= '0;
          fcnt <= fcnt + 1'b1;
        end else begin
          idx  <= idx + 1'b1;
        end
      end
      if (accept) begin
        shadow <= wide_data;
        idx    <= '0;
      end
    end
  end

  // Beat fields are driven purely from registers, so they hold under backpressure.
  assign beat_valid  = (state == SEND);
  assign busy        = (state == SEND);
  assign beat_data   = shadow[idx*BEAT_W +: BEAT_W];
  assign beat_idx    = idx;
  assign beat_last   = beat_valid && at_last;
  assign frame_count = fcnt;

endmodule

// File: tb/tb_wide_bus_beat_serializer.sv
// Self-checking bench: reset/handshake vector table, directed multi-cycle
// sequences and randomized traffic against a queue-based beat model.
module tb_wide_bus_beat_serializer;

  localparam int WW = 1024;
  localparam int BW = 32;
  localparam int NB = WW / BW;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, wv, br;
  logic [WW-1:0] wd;
  logic          wr, bv, bl, busy;
  logic [BW-1:0] bd;
  logic [4:0]    bidx;
  logic [CW-1:0] fc;

  always #5 clk = ~clk;

  wide_bus_beat_serializer #(.WIDE_W(WW), .BEAT_W(BW), .COUNT_W(CW)) dut (
    .main_clk_100mhz(clk), .reset(rst),
    .wide_valid(wv), .wide_ready(wr), .wide_data(wd),
    .beat_valid(bv), .beat_ready(br), .beat_data(bd),
    .beat_idx(bidx), .beat_last(bl), .frame_count(fc), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a queue of beats still owed to the sink.
  typedef struct {
    logic [BW-1:0] data;
    int            idx;
    bit            last;
  } beat_t;

  beat_t q[$];
  int    m_frames = 0;

  task automatic cycle();
    bit mready;
    @(negedge clk);
    mready = (q.size() == 0) || (q.size() == 1 && br);
    chk("wide_ready", wr, !rst && mready);
    chk("beat_valid", bv, q.size() > 0);
    chk("busy", busy, q.size() > 0);
    chk("frame_count", fc, m_frames % (1 << CW));
    if (q.size() > 0) begin
      chk("beat_data", bd, q[0].data);
      chk("beat_idx", bidx, q[0].idx);
      chk("beat_last", bl, q[0].last);
    end else begin
      chk("beat_last_idle", bl, 0);
    end
    if (rst) begin
      q.delete();
      m_frames = 0;
    end else begin
      if (q.size() > 0 && br) begin
        if (q[0].last) m_frames++;
        void'(q.pop_front());
      end
      if (wv && mready) begin
        for (int k = 0; k < NB; k++) begin
          beat_t b;
          b.data = wd[k*BW +: BW];
          b.idx  = k;
          b.last = (k == NB - 1);
          q.push_back(b);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic make_word(input logic [31:0] base, output logic [WW-1:0] w);
    for (int k = 0; k < NB; k++) w[k*BW +: BW] = base + k;
  endtask

  task automatic rand_word(output logic [WW-1:0] w);
    for (int k = 0; k < NB; k++) w[k*BW +: BW] = $urandom;
  endtask

  task automatic run(input int n, input bit v, input bit r);
    for (int i = 0; i < n; i++) begin
      wv = v; br = r;
      cycle();
    end
  endtask

  typedef struct {
    bit       rst, wv, br;
    bit       exp_wr, exp_bv, exp_busy;
    int       exp_idx;
  } vec_t;

  vec_t vt[7];

  initial begin
    logic [WW-1:0] wa, wb;
    vt[0] = '{1, 1, 1, 0, 0, 0, 0};  // reset held: ready forced low
    vt[1] = '{0, 0, 1, 1, 0, 0, 0};  // idle, ready
    vt[2] = '{0, 1, 1, 1, 0, 0, 0};  // accept
    vt[3] = '{0, 0, 0, 0, 1, 1, 0};  // beat 0 stalled
    vt[4] = '{0, 1, 1, 0, 1, 1, 0};  // beat 0 fires, new word refused
    vt[5] = '{1, 0, 1, 0, 1, 1, 1};  // reset mid-frame
    vt[6] = '{0, 0, 1, 1, 0, 0, 0};  // back to idle
    rst = 1'b1; wv = 1'b0; br = 1'b1;
    make_word(32'h11110000, wd);
    for (int i = 0; i < 7; i++) begin
      rst = vt[i].rst; wv = vt[i].wv; br = vt[i].br;
      @(negedge clk);
      chk($sformatf("vec%0d_wide_ready", i), wr, vt[i].exp_wr);
      chk($sformatf("vec%0d_beat_valid", i), bv, vt[i].exp_bv);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].exp_busy);
      chk($sformatf("vec%0d_beat_idx", i), bidx, vt[i].exp_idx);
      if (i == 0 || i == 6) begin
        chk($sformatf("vec%0d_frame_count", i), fc, 0);
        chk($sformatf("vec%0d_beat_data", i), bd, 0);
      end
      @(posedge clk);
      #1;
    end

    // model-tracked phase starts from a clean reset
    rst = 1'b1; run(1, 0, 1);
    rst = 1'b0;

    // single word, sink always ready
    make_word(32'hA5000000, wd);
    run(1, 1, 1);
    run(NB + 2, 0, 1);

    // two words back-to-back, valid held
    make_word(32'hB0000000, wd);
    run(1, 1, 1);
    make_word(32'hC0000000, wd);
    run(NB, 1, 1);
    run(NB + 2, 0, 1);

    // backpressure at idx 7
    make_word(32'hD0000000, wd);
    run(1, 1, 1);
    run(7, 0, 1);
    run(5, 0, 0);
    run(NB, 0, 1);

    // reset mid-frame at idx 10, then a fresh word
    make_word(32'hE0000000, wd);
    run(1, 1, 1);
    run(10, 0, 1);
    rst = 1'b1; run(1, 0, 1);
    rst = 1'b0;
    make_word(32'hF0000000, wd);
    run(1, 1, 1);
    run(NB + 1, 0, 1);

    // new word offered from idx 3 onward must wait for the last beat
    make_word(32'h12000000, wa);
    make_word(32'h34000000, wb);
    wd = wa; run(1, 1, 1);
    run(3, 0, 1);
    wd = wb; run(NB - 3, 1, 1);
    run(NB + 2, 0, 1);

    // 17 frames to wrap the 4-bit counter
    rst = 1'b1; run(1, 0, 1);
    rst = 1'b0;
    for (int f = 0; f < 17; f++) begin
      rand_word(wd);
      run(1, 1, 1);
      run(NB - 1, 0, 1);
    end
    run(2, 0, 1);
    chk("wrap_frame_count", fc, 1);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) rand_word(wd);
      wv = $urandom_range(0, 1);
      br = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
